// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake and serial outputs of the UART TX controller.
interface uart_tx_ctrl_if #(parameter int size = 8);
  logic [size-1:0] ParallelData;
  logic            DataValid;
  logic            ParityEnable;
  logic            ParityBit;
  logic            TxOut;
  logic            Busy;

  modport master (output ParallelData, DataValid, ParityEnable, ParityBit,
                  input  TxOut, Busy);
  modport slave  (input  ParallelData, DataValid, ParityEnable, ParityBit,
                  output TxOut, Busy);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX framer/serializer: start, data LSB first, optional parity, stop.
// One bit per CLK; TxOut and Busy come straight from flops.
module uart_tx_ctrl #(parameter int size = 8) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);
  localparam int CW = $clog2(size) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;
  logic [size-1:0] shift, shift_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            par, par_nx;
  logic            pen, pen_nx;
  logic            tx_q, tx_nx;
  logic            busy_q, busy_nx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      shift  <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      pen    <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      shift  <= shift_nx;
      cnt    <= cnt_nx;
      par    <= par_nx;
      pen    <= pen_nx;
      tx_q   <= tx_nx;
      busy_q <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    cnt_nx   = cnt;
    par_nx   = par;
    pen_nx   = pen;
    case (state)
      IDLE: if (bus.DataValid) begin
        shift_nx = bus.ParallelData;
        pen_nx   = bus.ParityEnable;
        state_nx = START;
      end
      // parity calculator output settles one cycle after the strobe
      START: begin
        par_nx   = bus.ParityBit;
        cnt_nx   = '0;
        state_nx = DATA;
      end
      DATA: begin
        shift_nx = shift >> 1;
        cnt_nx   = cnt + 1'b1;
        if (cnt == CW'(size - 1)) state_nx = pen ? PARITY : STOP;
      end
      PARITY:  state_nx = STOP;
      STOP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // outputs decoded from the next state so they can be registered
    tx_nx   = 1'b1;
    busy_nx = 1'b1;
    case (state_nx)
      IDLE:    busy_nx = 1'b0;
      START:   tx_nx   = 1'b0;
      DATA:    tx_nx   = shift_nx[0];
      PARITY:  tx_nx   = par_nx;
      default: tx_nx   = 1'b1;
    endcase
  end

  assign bus.TxOut = tx_q;
  assign bus.Busy  = busy_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + random frames against a bit-list model of the UART frame.
module tb_uart_tx_ctrl;
  localparam int SIZE = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   s1, s2, s_dummy;

  uart_tx_ctrl_if #(.size(SIZE)) bus ();
  uart_tx_ctrl #(.size(SIZE)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts on the current cycle's edge, then walks the expected frame.
  task automatic run_frame(input logic [SIZE-1:0] d, input logic pe, input logic pb,
                           input bit intrude, output int start_cyc);
    logic exp_q[$];
    int   busy_n;
    busy_n = 0;
    bus.ParallelData = d;
    bus.ParityEnable = pe;
    bus.DataValid    = 1'b1;
    tick();
    start_cyc = cyc;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < SIZE; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(pb);
    exp_q.push_back(1'b1);
    bus.DataValid    = 1'b0;
    bus.ParityBit    = pb;
    bus.ParallelData = SIZE'($urandom);
    bus.ParityEnable = 1'($urandom_range(0, 1));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) tick();
      chk("tx_bit", bus.TxOut, exp_q[k]);
      chk("busy_frame", bus.Busy, 1);
      busy_n += int'(bus.Busy);
      if (k == 1) bus.ParityBit = 1'($urandom_range(0, 1));
      if (intrude && k == 3) begin
        bus.DataValid    = 1'b1;
        bus.ParallelData = SIZE'(8'h3C);
      end
      if (intrude && k == 4) begin
        bus.DataValid = 1'b0;
        bus.ParityBit = ~bus.ParityBit;
      end
    end
    tick();
    chk("idle_tx", bus.TxOut, 1);
    chk("idle_busy", bus.Busy, 0);
    chk("busy_len", busy_n, pe ? SIZE + 3 : SIZE + 2);
  endtask

  initial begin
    bus.ParallelData = '0;
    bus.DataValid    = 1'b0;
    bus.ParityEnable = 1'b0;
    bus.ParityBit    = 1'b0;
    #12;
    chk("rst_tx", bus.TxOut, 1);
    chk("rst_busy", bus.Busy, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("post_rst_busy", bus.Busy, 0);

    run_frame(SIZE'(8'hA5), 1'b1, 1'b0, 1'b0, s_dummy);
    run_frame(SIZE'(8'h01), 1'b1, 1'b0, 1'b0, s_dummy);
    run_frame(SIZE'(8'hFF), 1'b0, 1'b0, 1'b0, s_dummy);
    run_frame(SIZE'(8'hC3), 1'b1, 1'b1, 1'b1, s_dummy);
    run_frame(SIZE'(8'h5A), 1'b0, 1'b0, 1'b1, s_dummy);

    run_frame(SIZE'(8'h55), 1'b1, 1'b0, 1'b0, s1);
    run_frame(SIZE'(8'hAA), 1'b1, 1'b1, 1'b0, s2);
    chk("b2b_spacing", s2 - s1, SIZE + 4);

    // abort mid-DATA while the line is low (bit 3 of 8'h96 is 0)
    bus.ParallelData = SIZE'(8'h96);
    bus.ParityEnable = 1'b1;
    bus.DataValid    = 1'b1;
    tick();
    bus.DataValid = 1'b0;
    bus.ParityBit = 1'b1;
    repeat (4) tick();
    chk("mid_data_tx", bus.TxOut, 0);
    #2 RST = 1'b1;
    #1;
    chk("abort_tx", bus.TxOut, 1);
    chk("abort_busy", bus.Busy, 0);
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("quiet_tx", bus.TxOut, 1);
      chk("quiet_busy", bus.Busy, 0);
    end

    // strobe across an edge with RST still high must be dropped
    RST = 1'b1;
    bus.ParallelData = SIZE'(8'h81);
    bus.ParityEnable = 1'b0;
    bus.DataValid    = 1'b1;
    tick();
    chk("rst_hold_busy", bus.Busy, 0);
    RST = 1'b0;
    run_frame(SIZE'(8'h81), 1'b0, 1'b0, 1'b0, s_dummy);

    for (int n = 0; n < 20; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_busy", bus.Busy, 0);
        chk("gap_tx", bus.TxOut, 1);
      end
      run_frame(SIZE'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), s_dummy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
